gelato_fetch_scheduler: RTL and testbench

Per-SM warp fetch scheduler that holds each resident warp's next PC and active thread mask, and picks one eligible warp per cycle with round-robin arbitration. Sits directly upstream of the instruction fetch unit and drives its `din_valid`/`din_ready`/`din` (pc_info_t) handshake. Each warp has at most one instruction in flight. The warp becomes eligible again only when decode or writeback returns its next PC through the update port.

---
 rtl/gelato_types.sv | 32 +++
 rtl/gelato_rr_arbiter.sv | 39 +++
 rtl/gelato_fetch_scheduler.sv | 129 ++++++++++++
 tb/tb_gelato_fetch_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gelato_types.sv
// Shared types for the gelato SM front end: warp identifiers, PC/mask words,
// the fetch request record and the per-warp scheduler context.
package gelato_types;

   localparam int NUM_WARPS_DEFAULT = 8;

   typedef logic [31:0]                            addr_t;
   typedef logic [31:0]                            thread_mask_t;
   typedef logic [$clog2(NUM_WARPS_DEFAULT)-1:0]   warp_num_t;
   typedef logic [2:0]                             split_table_num_t;

   typedef struct packed {
      addr_t            pc;
      warp_num_t        warp_num;
      split_table_num_t split_table_num;
      thread_mask_t     thread_mask;
   } pc_info_t;

   typedef struct packed {
      logic             active;
      logic             pending;
      addr_t            pc;
      thread_mask_t     mask;
      split_table_num_t stn;
   } warp_ctx_t;

   // A warp with every thread masked off has nothing to fetch.
   function automatic logic warp_eligible(input warp_ctx_t c);
      return c.active && !c.pending && (c.mask != '0);
   endfunction

endpackage

// File: rtl/gelato_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after rr_ptr
// (wrapping modulo N) is granted.
module gelato_rr_arbiter #(
   parameter int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] rr_ptr,
   output logic         grant_valid,
   output logic [W-1:0] grant_idx
);

   logic [N-1:0] w_rot;
   logic [W-1:0] w_off;

   // w_rot[k] is the request of warp (rr_ptr + k) mod N; N is a power of two
   // so the W-bit add wraps for free.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_rot
         logic [W-1:0] w_idx;
         assign w_idx     = rr_ptr + W'(gi);
         assign w_rot[gi] = req[w_idx];
      end
   endgenerate

   always_comb begin
      w_off = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_off = W'(k);
         end
      end
   end

   assign grant_valid = |w_rot;
   assign grant_idx   = rr_ptr + w_off;

endmodule

// File: rtl/gelato_fetch_scheduler.sv
// Per-SM warp fetch scheduler: tracks each warp's next PC/mask and issues one
// eligible warp per cycle, round-robin, into a registered fetch request.
module gelato_fetch_scheduler
   import gelato_types::*;
#(
   parameter int NUM_WARPS = NUM_WARPS_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             launch_valid,
   input  warp_num_t        launch_warp,
   input  addr_t            launch_pc,
   input  thread_mask_t     launch_mask,
   input  logic             update_valid,
   input  warp_num_t        update_warp,
   input  addr_t            update_pc,
   input  thread_mask_t     update_mask,
   input  split_table_num_t update_split_table_num,
   input  logic             update_exit,
   output logic             dout_valid,
   input  logic             dout_ready,
   output pc_info_t         dout,
   output logic             idle
);

   localparam int WW = $clog2(NUM_WARPS);

   warp_ctx_t          w_ctx_all [NUM_WARPS];
   warp_ctx_t          w_grant_ctx;
   logic [NUM_WARPS-1:0] w_req;
   logic [NUM_WARPS-1:0] w_active;
   logic               w_grant_valid;
   logic [WW-1:0]      w_grant_idx;
   logic [WW-1:0]      w_launch_idx;
   logic [WW-1:0]      w_update_idx;
   logic               w_issue;

   logic               r_dout_valid;
   pc_info_t           r_dout;
   logic [WW-1:0]      r_rr_ptr;

   assign w_launch_idx = launch_warp[WW-1:0];
   assign w_update_idx = update_warp[WW-1:0];
   assign w_issue      = rdy && (!r_dout_valid || dout_ready) && w_grant_valid;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
         warp_ctx_t r_ctx;
         warp_ctx_t w_ctx_next;
         logic      w_upd_hit;
         logic      w_lch_hit;
         logic      w_grant_hit;

         // An accepted update implies the warp is active, so a same-warp launch
         // is rejected by the active check and the update naturally wins.
         assign w_upd_hit   = update_valid && (w_update_idx == WW'(gi))
                              && r_ctx.active && r_ctx.pending;
         assign w_lch_hit   = launch_valid && (w_launch_idx == WW'(gi)) && !r_ctx.active;
         assign w_grant_hit = w_issue && (w_grant_idx == WW'(gi));

         always_comb begin
            w_ctx_next = r_ctx;
            if (w_upd_hit) begin
               w_ctx_next.pc      = update_pc;
               w_ctx_next.mask    = update_mask;
               w_ctx_next.stn     = update_split_table_num;
               w_ctx_next.pending = 1'b0;
               w_ctx_next.active  = !update_exit;
            end else if (w_lch_hit) begin
               w_ctx_next.active  = 1'b1;
               w_ctx_next.pending = 1'b0;
               w_ctx_next.pc      = launch_pc;
               w_ctx_next.mask    = launch_mask;
               w_ctx_next.stn     = '0;
            end
            if (w_grant_hit) begin
               w_ctx_next.pending = 1'b1;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_ctx <= '0;
            end else if (rdy) begin
               r_ctx <= w_ctx_next;
            end
         end

         assign w_ctx_all[gi] = r_ctx;
         assign w_req[gi]     = warp_eligible(r_ctx);
         assign w_active[gi]  = r_ctx.active;
      end
   endgenerate

   gelato_rr_arbiter #(.N(NUM_WARPS)) u_arb (
      .req         (w_req),
      .rr_ptr      (r_rr_ptr),
      .grant_valid (w_grant_valid),
      .grant_idx   (w_grant_idx)
   );

   assign w_grant_ctx = w_ctx_all[w_grant_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dout_valid <= 1'b0;
         r_dout       <= '0;
         r_rr_ptr     <= '0;
      end else if (rdy) begin
         if (w_issue) begin
            r_dout_valid           <= 1'b1;
            r_dout.pc              <= w_grant_ctx.pc;
            r_dout.warp_num        <= warp_num_t'(w_grant_idx);
            r_dout.split_table_num <= w_grant_ctx.stn;
            r_dout.thread_mask     <= w_grant_ctx.mask;
            r_rr_ptr               <= w_grant_idx + WW'(1);
         end else if (dout_ready) begin
            r_dout_valid <= 1'b0;
         end
      end
   end

   assign dout_valid = r_dout_valid;
   assign dout       = r_dout;
   assign idle       = !(|w_active) && !r_dout_valid;

endmodule

// File: tb/tb_gelato_fetch_scheduler.sv
// Scoreboard bench for gelato_fetch_scheduler: expected fetch requests are queued
// as launches/updates are driven and popped when the scheduler presents them.
module tb_gelato_fetch_scheduler;
   import gelato_types::*;

   logic             clk = 1'b0;
   logic             rst;
   logic             rdy;
   logic             launch_valid;
   warp_num_t        launch_warp;
   addr_t            launch_pc;
   thread_mask_t     launch_mask;
   logic             update_valid;
   warp_num_t        update_warp;
   addr_t            update_pc;
   thread_mask_t     update_mask;
   split_table_num_t update_split_table_num;
   logic             update_exit;
   logic             dout_valid;
   logic             dout_ready;
   pc_info_t         dout;
   logic             idle;

   int       n_vec = 0;
   int       n_err = 0;
   pc_info_t exp_q[$];

   always #5 clk = ~clk;

   gelato_fetch_scheduler #(.NUM_WARPS(8)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .rdy                    (rdy),
      .launch_valid           (launch_valid),
      .launch_warp            (launch_warp),
      .launch_pc              (launch_pc),
      .launch_mask            (launch_mask),
      .update_valid           (update_valid),
      .update_warp            (update_warp),
      .update_pc              (update_pc),
      .update_mask            (update_mask),
      .update_split_table_num (update_split_table_num),
      .update_exit            (update_exit),
      .dout_valid             (dout_valid),
      .dout_ready             (dout_ready),
      .dout                   (dout),
      .idle                   (idle)
   );

   task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic pc_info_t mk(input addr_t pc, input int w, input logic [2:0] stn,
                                   input thread_mask_t m);
      pc_info_t p;
      p.pc              = pc;
      p.warp_num        = warp_num_t'(w);
      p.split_table_num = stn;
      p.thread_mask     = m;
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_launch(input int w, input addr_t pc, input thread_mask_t m);
      launch_valid = 1'b1;
      launch_warp  = warp_num_t'(w);
      launch_pc    = pc;
      launch_mask  = m;
      tick();
      launch_valid = 1'b0;
   endtask

   task automatic do_update(input int w, input addr_t pc, input thread_mask_t m,
                            input logic [2:0] stn, input logic ex);
      update_valid           = 1'b1;
      update_warp            = warp_num_t'(w);
      update_pc              = pc;
      update_mask            = m;
      update_split_table_num = stn;
      update_exit            = ex;
      tick();
      update_valid = 1'b0;
      update_exit  = 1'b0;
   endtask

   // Waits (bounded) for a presented request and compares it with the queue head.
   task automatic expect_issue(input string tag, input int max_wait, output int waited);
      waited = 0;
      while (!dout_valid && waited < max_wait) begin
         tick();
         waited++;
      end
      if (!dout_valid) begin
         check({tag, "_timeout"}, 70'(dout_valid), 70'd1);
      end else if (exp_q.size() == 0) begin
         check({tag, "_noexp"}, 70'(exp_q.size()), 70'd1);
      end else begin
         pc_info_t e;
         e = exp_q.pop_front();
         $display("issue %s: pc=%h warp=%0d stn=%0d mask=%h", tag, dout.pc, dout.warp_num,
                  dout.split_table_num, dout.thread_mask);
         check(tag, dout, e);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int           waited;
      int           wl [3];
      addr_t        cur_pc [8];
      thread_mask_t cur_m [8];

      rst = 1'b1; rdy = 1'b1; dout_ready = 1'b1;
      launch_valid = 1'b0; launch_warp = '0; launch_pc = '0; launch_mask = '0;
      update_valid = 1'b0; update_warp = '0; update_pc = '0; update_mask = '0;
      update_split_table_num = '0; update_exit = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_valid", 70'(dout_valid), 70'd0);
      check("rst_dout", dout, 70'd0);
      check("rst_idle", 70'(idle), 70'd1);

      // Launch latency: visible two cycles after the launch cycle.
      exp_q.push_back(mk(32'h100, 2, 3'd0, 32'hFFFF_FFFF));
      do_launch(2, 32'h100, 32'hFFFF_FFFF);
      check("l2_t1_valid", 70'(dout_valid), 70'd0);
      tick();
      expect_issue("l2_issue", 0, waited);
      tick();
      for (int i = 0; i < 4; i++) begin
         check("l2_noreissue", 70'(dout_valid), 70'd0);
         tick();
      end
      check("l2_idle_busy", 70'(idle), 70'd0);

      // Update latency, then exit while the request is still held.
      dout_ready = 1'b0;
      exp_q.push_back(mk(32'h200, 2, 3'd1, 32'h0000_FFFF));
      do_update(2, 32'h200, 32'h0000_FFFF, 3'd1, 1'b0);
      check("upd_t1_valid", 70'(dout_valid), 70'd0);
      tick();
      expect_issue("upd_issue", 0, waited);
      do_update(2, 32'hDEAD, 32'h0, 3'd0, 1'b1);
      check("exit_idle_busy", 70'(idle), 70'd0);
      dout_ready = 1'b1;
      tick();
      check("exit_drained", 70'(dout_valid), 70'd0);
      check("exit_idle", 70'(idle), 70'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("exit_noissue", 70'(dout_valid), 70'd0);
      end

      // Three warps launched behind a stalled output; then round-robin with returns.
      wl[0] = 0; wl[1] = 1; wl[2] = 3;
      cur_pc[0] = 32'h0;    cur_m[0] = 32'h0000_0001;
      cur_pc[1] = 32'h1000; cur_m[1] = 32'h0000_0003;
      cur_pc[3] = 32'h3000; cur_m[3] = 32'hF0F0_F0F0;
      dout_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(mk(cur_pc[wl[i]], wl[i], 3'd0, cur_m[wl[i]]));
         do_launch(wl[i], cur_pc[wl[i]], cur_m[wl[i]]);
      end
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", 70'(dout_valid), 70'd1);
         check("stall_hold", dout, mk(32'h0, 0, 3'd0, 32'h0000_0001));
         tick();
      end
      dout_ready = 1'b1;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 3; i++) begin
            expect_issue($sformatf("rr%0d_w%0d", r, wl[i]), 4, waited);
            if (r != 0 || i != 0) check("rr_thru", 70'(waited), 70'd0);
            if (r < 2) begin
               cur_pc[wl[i]] = cur_pc[wl[i]] + 32'd4;
               exp_q.push_back(mk(cur_pc[wl[i]], wl[i], 3'(r + 1), cur_m[wl[i]]));
               update_valid           = 1'b1;
               update_warp            = warp_num_t'(wl[i]);
               update_pc              = cur_pc[wl[i]];
               update_mask            = cur_m[wl[i]];
               update_split_table_num = 3'(r + 1);
            end
            tick();
            update_valid = 1'b0;
         end
      end
      check("rr_done", 70'(dout_valid), 70'd0);

      // Ignored launch/update and rdy=0 freeze while warp 1 waits behind warp 0.
      dout_ready = 1'b0;
      exp_q.push_back(mk(32'h20, 0, 3'd0, 32'h0000_0001));
      do_update(0, 32'h20, 32'h0000_0001, 3'd0, 1'b0);
      exp_q.push_back(mk(32'h2000, 1, 3'd4, 32'h0000_0003));
      do_update(1, 32'h2000, 32'h0000_0003, 3'd4, 1'b0);
      do_launch(1, 32'h999, 32'hFFFF_FFFF);
      do_update(1, 32'h777, 32'h0000_0003, 3'd7, 1'b0);
      rdy = 1'b0; dout_ready = 1'b1;
      launch_valid = 1'b1; launch_warp = 3'd4; launch_pc = 32'h4444; launch_mask = 32'h1;
      update_valid = 1'b1; update_warp = 3'd3; update_pc = 32'h3333; update_mask = 32'h1;
      update_split_table_num = 3'd3;
      for (int i = 0; i < 2; i++) begin
         check("rdy0_valid", 70'(dout_valid), 70'd1);
         check("rdy0_hold", dout, mk(32'h20, 0, 3'd0, 32'h0000_0001));
         tick();
      end
      launch_valid = 1'b0; update_valid = 1'b0; rdy = 1'b1;
      expect_issue("bnd_w0", 0, waited);
      tick();
      expect_issue("bnd_w1_oldpc", 0, waited);
      tick();
      for (int i = 0; i < 4; i++) begin
         check("bnd_quiet", 70'(dout_valid), 70'd0);
         tick();
      end
      check("bnd_idle", 70'(idle), 70'd0);

      // Same-warp launch+update (update wins), then different-warp pair (both apply).
      exp_q.push_back(mk(32'hABC0, 3, 3'd5, 32'h0000_FF00));
      launch_valid = 1'b1; launch_warp = 3'd3; launch_pc = 32'h555; launch_mask = 32'h1;
      update_valid = 1'b1; update_warp = 3'd3; update_pc = 32'hABC0; update_mask = 32'h0000_FF00;
      update_split_table_num = 3'd5;
      tick();
      exp_q.push_back(mk(32'h5000, 5, 3'd0, 32'h0000_00FF));
      exp_q.push_back(mk(32'h24, 0, 3'd2, 32'h0000_0001));
      launch_warp = 3'd5; launch_pc = 32'h5000; launch_mask = 32'h0000_00FF;
      update_warp = 3'd0; update_pc = 32'h24; update_mask = 32'h1; update_split_table_num = 3'd2;
      tick();
      launch_valid = 1'b0; update_valid = 1'b0;
      expect_issue("lu_same", 0, waited);
      tick();
      expect_issue("lu_diff_w5", 0, waited);
      tick();
      expect_issue("lu_diff_w0", 0, waited);
      tick();

      // Asynchronous reset with a request held in the output register.
      dout_ready = 1'b0;
      exp_q.push_back(mk(32'h5004, 5, 3'd1, 32'h0000_00FF));
      do_update(5, 32'h5004, 32'h0000_00FF, 3'd1, 1'b0);
      expect_issue("pre_rst", 3, waited);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", 70'(dout_valid), 70'd0);
      check("arst_idle", 70'(idle), 70'd1);
      check("arst_dout", dout, 70'd0);
      tick();
      rst = 1'b0; dout_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("post_rst_quiet", 70'(dout_valid), 70'd0);
         tick();
      end
      exp_q.push_back(mk(32'h600, 6, 3'd0, 32'h0000_0001));
      do_launch(6, 32'h600, 32'h0000_0001);
      check("post_rst_t1", 70'(dout_valid), 70'd0);
      tick();
      expect_issue("post_rst_issue", 0, waited);
      tick();
      check("q_empty", 70'(exp_q.size()), 70'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
